// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg
// Shared definitions for the datapath sequencing controller:
//   - FSM state encoding (IDLE, LOAD, FETCH, EXEC, STORE, DONE)
//   - bit positions inside the 4-bit clock-enable word {Q, R2, R1, R0}
//   - 4:1 operand mux select codes
//   - ce_bit(): one-hot clock-enable helper
package datapath_ctrl_pkg;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_FETCH = 3'd2;
  localparam state_t ST_EXEC  = 3'd3;
  localparam state_t ST_STORE = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  localparam int CE_R0 = 0;
  localparam int CE_R1 = 1;
  localparam int CE_R2 = 2;
  localparam int CE_Q  = 3;

  localparam logic [1:0] SEL_R0   = 2'b00;
  localparam logic [1:0] SEL_R1   = 2'b01;
  localparam logic [1:0] SEL_R2   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  function automatic logic [3:0] ce_bit(input int idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/datapath_ctrl_rep_counter.sv
// rep_counter
// Loadable down-counter holding the number of remaining EXEC cycles.
// Ports:
//   i_clock     rising-edge clock
//   i_clear     synchronous active-high clear (count -> 0)
//   i_load      load i_load_val (has priority over i_dec)
//   i_load_val  value to load
//   i_dec       decrement by one; saturates at zero so it can never wrap
//   o_zero      count == 0
//   o_is_one    count == 1
module rep_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero   = (r_count == '0);
  assign o_is_one = (r_count == CNT_W'(1));

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl
// Start/busy/done sequencer for the three-register/accumulator datapath:
// load R0/R1 from w, move R0 into Q, apply op with R1 'count' times, write Q
// into R2. Moore outputs decoded from the registered state and latched op.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; all outputs 0
//   LOAD  | R0, R1 capture w (ce=0011)
//   FETCH | Q <= R0 via ALU pass-B (ce=1000)
//   EXEC  | Q <= Q op R1, once per remaining count (ce=1000)
//   STORE | R2 <= qout (M2=1, ce=0100)
//   DONE  | one-cycle done pulse
//
// Ports:
//   clock, clear         rising-edge clock, synchronous active-high reset
//   start                begin a sequence (IDLE only)
//   op, cin_op, count    ALU select / carry-in / repeat count, latched at start
//   abort                only with DATAPATH_CTRL_ABORT_EN: return to IDLE silently
//   M0, M1, M2           register input mux selects (0 = w, 1 = qout)
//   ce                   clock enables {Q, R2, R1, R0}
//   sel                  operand mux select
//   s, Cin               ALU select and carry-in
//   busy, done           handshake
// Optional feature macro: DATAPATH_CTRL_ABORT_EN
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter logic [2:0]  S_LOADB = 3'b111,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cin_op,
  input  logic [CNT_W-1:0] count,
`ifdef DATAPATH_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             M0,
  output logic             M1,
  output logic             M2,
  output logic [3:0]       ce,
  output logic [1:0]       sel,
  output logic [2:0]       s,
  output logic             Cin,
  output logic             busy,
  output logic             done
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_op;
  logic       r_cin_op;
  logic       w_cnt_load;
  logic       w_cnt_dec;
  logic       w_cnt_zero;
  logic       w_cnt_is_one;

  rep_counter #(.CNT_W(CNT_W)) u_rep_counter (
    .i_clock    (clock),
    .i_clear    (clear),
    .i_load     (w_cnt_load),
    .i_load_val (count),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero),
    .o_is_one   (w_cnt_is_one)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_cnt_load  = 1'b1;
        end
      end
      ST_LOAD:  w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = w_cnt_zero ? ST_STORE : ST_EXEC;
      ST_EXEC: begin
        w_cnt_dec = 1'b1;
        // Zero is unreachable here; treating it like one keeps EXEC from hanging.
        if (w_cnt_is_one || w_cnt_zero) begin
          w_state_nxt = ST_STORE;
        end
      end
      ST_STORE: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
`ifdef DATAPATH_CTRL_ABORT_EN
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_dec   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= ST_IDLE;
      r_op     <= 3'b000;
      r_cin_op <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_load) begin
        r_op     <= op;
        r_cin_op <= cin_op;
      end
    end
  end

  always_comb begin
    M0   = 1'b0;
    M1   = 1'b0;
    M2   = 1'b0;
    ce   = 4'b0000;
    sel  = SEL_R0;
    s    = 3'b000;
    Cin  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_LOAD: begin
        busy = 1'b1;
        ce   = ce_bit(CE_R0) | ce_bit(CE_R1);
      end
      ST_FETCH: begin
        busy = 1'b1;
        sel  = SEL_R0;
        s    = S_LOADB;
        ce   = ce_bit(CE_Q);
      end
      ST_EXEC: begin
        busy = 1'b1;
        sel  = SEL_R1;
        s    = r_op;
        Cin  = r_cin_op;
        ce   = ce_bit(CE_Q);
      end
      ST_STORE: begin
        busy = 1'b1;
        M2   = 1'b1;
        ce   = ce_bit(CE_R2);
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Sequencing controller that drives the control inputs of the three-register/accumulator datapath: load R0 and R1 from the external `w` bus, move R0 into the accumulator Q, apply an ALU operation with R1 as operand a programmable number of times, and write Q back into R2. The controller sits beside the datapath, shares its `clock` and `clear`, and replaces hand-driven control-word stimulus with a start/busy/done handshake.

## Interface
- `S_LOADB`, default 3'b111: ALU select code that routes the B operand (mux output) to the ALU result.
- `CNT_W`, default 4: width of the repeat count.
- `clock` input 1: single clock, rising edge.
- `clear` input 1: reset, synchronous, active-high.
- `start` input 1: begin a sequence; sampled only in IDLE.
- `op` input 3: ALU select applied during EXEC; latched at start.
- `cin_op` input 1: ALU carry-in during EXEC; latched at start.
- `count` input CNT_W: number of EXEC cycles; latched at start.
- `abort` input 1: present only with `DATAPATH_CTRL_ABORT_EN`.
- `M0`, `M1`, `M2` output 1 each: register input mux selects (0 = `w` bit, 1 = `qout`).
- `ce` output 4: clock enables {Q, R2, R1, R0}.
- `sel` output 2: 4:1 mux select (00 R0, 01 R1, 10 R2, 11 zero).
- `s` output 3: ALU select.
- `Cin` output 1: ALU carry-in.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.

## Operation
- Moore FSM; every output is a function of the registered state and the latched `op`, `cin_op`. In any state not listed below, all outputs are 0.
- IDLE: `busy`=0. If `start`=1, latch `op`, `cin_op`, and `count` into the repeat counter, then go to LOAD.
- LOAD: `ce`=0011, `M0`=`M1`=0. Go to FETCH.
- FETCH: `sel`=00, `s`=`S_LOADB`, `ce`=1000. Go to EXEC if the counter is non-zero; otherwise go to STORE.
- EXEC: `sel`=01, `s`=latched `op`, `Cin`=latched `cin_op`, `ce`=1000. Decrement the counter each cycle. Leave for STORE in the cycle where the counter reads 1.
- STORE: `M2`=1, `ce`=0100. Go to DONE.
- DONE: `done`=1, `busy`=1. Go to IDLE.
- `start` while `busy`=1 is ignored. No queueing.
- `count` is unsigned. The maximum value 2^CNT_W−1 gives that many EXEC cycles. There is no wrap.
- `clear` overrides everything: next state IDLE, counter 0, latched `op`/`cin_op` 0.

## Timing
- Reset values: all outputs 0, state IDLE.
- With `start` sampled at edge k and `count`=N: LOAD is in cycle k+1, FETCH in k+2, EXEC in k+3..k+2+N, STORE in k+3+N, DONE in k+4+N.
- `done` is high for exactly one cycle. `start` is accepted again in the cycle after DONE. Back-to-back sequences leave one IDLE cycle between them.
- `clear` mid-sequence: outputs are 0 from the next cycle. A partially updated datapath is not restored.
- `count`, `op` and `cin_op` changing after the start edge have no effect.

## Configuration
- `DATAPATH_CTRL_ABORT_EN` defined: the `abort` port exists. With `abort`=1 in any non-IDLE state, the next state is IDLE with all outputs 0 and no `done` pulse. `abort` together with `start` in IDLE is ignored.
- Not defined: no `abort` port. Every sequence runs to DONE unless `clear` is asserted.

## Structure
- Shared package `datapath_ctrl_pkg`:
  - state enumeration (IDLE, LOAD, FETCH, EXEC, STORE, DONE);
  - `ce` bit-index constants;
  - `sel` codes `SEL_R0`, `SEL_R1`, `SEL_R2`, `SEL_ZERO`.
- One natural sub-module: `rep_counter`, a loadable down-counter with a zero flag and an is-one flag, CNT_W wide, with synchronous `clear`.
- The FSM and output decode stay in the top module.

## Test plan
- Reset: assert `clear` for 2 cycles after random activity -> all outputs 0, `busy`=0, and no `done` until the next `start`.
- `start`, `count`=3, `op`=3'b010, `cin_op`=1:
  - -> `ce` sequence 0011, 1000, 1000×3, 0100, 0000;
  - -> `s`=010 and `Cin`=1 only in the three EXEC cycles;
  - -> `done` 7 cycles after the start edge.
- `count`=0 -> FETCH goes directly to STORE, and `done` arrives 4 cycles after start.
- `count`=15 -> 15 EXEC cycles, `done` at cycle 19, no counter wrap.
- `start` pulsed during EXEC with a different `op` -> ignored, and the original `op` persists. `clear` during EXEC -> all outputs 0 next cycle.
- With `DATAPATH_CTRL_ABORT_EN`: `abort` in the FETCH cycle -> IDLE next cycle, no `done`. A `start` two cycles later runs a full sequence normally.
